xor_bus_master: RTL and testbench
=================================

Name: xor_bus_master

Overview:
- Upstream command stage for the XOR register-mapped core.
- Accepts operand pairs on a valid/ready stream.
- Drives the core's write and read bus interfaces to push A and B, polls the Y status register, then pops Y.
- Returns each result, or a timeout error, on a downstream valid/ready stream. One operation in flight at a time.

Parameters:
- ADDR_W, 3, bus address width.
- TIMEOUT, 64, max cycles any wait state may stall before the operation aborts with an error; legal range 2..255.
- CNT_W, 8, width of the wait counter and of the error counter.

Ports:
- CLK in 1: clock, rising edge.
- RST_N in 1: asynchronous active-low reset.
- op_valid in 1: operand pair valid.
- op_ready out 1: operand pair accepted when op_valid && op_ready.
- op_a in 1: operand A.
- op_b in 1: operand B.
- res_valid out 1: result valid.
- res_ready in 1: downstream accepts the result.
- res_y out 1: A^B as read back from the core.
- res_err out 1: operation timed out; res_y is 0.
- wr_en out 1: bus write request.
- wr_addr out ADDR_W: write address.
- wr_data out 1: write data.
- wr_rdy in 1: write completes in any cycle with wr_en && wr_rdy.
- rd_en out 1: bus read request.
- rd_addr out ADDR_W: read address.
- rd_data in 1: read data, combinational; sampled when rd_en && rd_rdy.
- rd_rdy in 1: read completes in any cycle with rd_en && rd_rdy.
- busy out 1: state != IDLE.
- err_cnt out CNT_W: saturating count of timed-out operations.

Behaviour:
- Reset is asynchronous, active-low, and applies in any state, including mid-operation.
  - Reset values: state=IDLE, wr_en=0, rd_en=0, wr_addr/rd_addr/wr_data=0, res_valid=0, res_y=0, res_err=0, err_cnt=0, wait_cnt=0, operand regs=0.
  - op_ready=1 in IDLE once RST_N deasserts.
  - A bus transaction interrupted by reset is abandoned; no recovery sequence is issued.
- Address map: 0=A not-full, 1=B not-full, 2=Y not-empty, 3=Y data (pop), 4=A FIFO write, 5=B FIFO write.
- Bus outputs are a Moore decode of the state plus the operand registers; they are held stable for every cycle of a state.
- FSM states:
  - IDLE: op_ready=1. On handshake, latch op_a/op_b and go to CHK_A.
  - CHK_A: rd_en=1, rd_addr=0. Move to WR_A on a completed read with rd_data=1; otherwise stay.
  - WR_A: wr_en=1, wr_addr=4, wr_data=a_q. Move to CHK_B on wr_rdy.
  - CHK_B: rd_en=1, rd_addr=1. Move to WR_B on a completed read with rd_data=1.
  - WR_B: wr_en=1, wr_addr=5, wr_data=b_q. Move to POLL_Y on wr_rdy.
  - POLL_Y: rd_en=1, rd_addr=2. Move to RD_Y on a completed read with rd_data=1.
  - RD_Y: rd_en=1, rd_addr=3. On completion, capture res_y=rd_data, res_err=0, go to RESP.
  - RESP: res_valid=1, outputs held. On res_ready go to IDLE; op_ready stays 0 until IDLE is reached, so results never overlap.
- Latency with every bus response immediately favourable:
  - Cycle 0 = op handshake.
  - Cycles 1..6 = CHK_A, WR_A, CHK_B, WR_B, POLL_Y, RD_Y.
  - res_valid is high from cycle 7.
- Timeout:
  - wait_cnt clears on every state change.
  - wait_cnt increments each cycle a wait state (CHK_A..RD_Y) does not advance.
  - If it does not advance while wait_cnt==TIMEOUT-1, go to RESP with res_err=1 and res_y=0, and increment err_cnt (saturates at 2^CNT_W-1).
  - A condition met in the same cycle as expiry takes priority: the state advances and no error is raised.
- A failed status poll (rd_data=0) consumes nothing; only RD_Y pops.
- res_ready asserted outside RESP has no effect.
- Operand inputs changing while busy have no effect.

Decomposition:
- Package xor_bus_pkg holds:
  - ADDR_A_STAT=0, ADDR_B_STAT=1, ADDR_Y_STAT=2, ADDR_Y_DATA=3, ADDR_A_WR=4, ADDR_B_WR=5.
  - The state enum.
  - Default ADDR_W and CNT_W.
- One sub-module, xor_wait_timer (counter, clear, enable, expiry flag), instantiated once.

Test Plan:
- Reset, then op (a=1,b=0) with all rdy=1 and rd_data=1 on polls -> bus sequence rd0, wr4/1, rd1, wr5/0, rd2, rd3; res_valid in cycle 7; res_y=rd_data at RD_Y; res_err=0.
- Status at addr 0 reads 0 for 5 cycles then 1 -> stays in CHK_A 5 extra cycles, no write issued early; result correct, err_cnt=0.
- TIMEOUT=4, wr_rdy held 0 in WR_A -> after 4 stalled cycles res_valid=1, res_err=1, res_y=0; err_cnt=1; next op accepted normally.
- res_ready low for 10 cycles in RESP -> res_valid and res_y held; op_ready=0 throughout; IDLE one cycle after res_ready=1.
- RST_N pulsed low during WR_B -> all outputs at reset values immediately (async); busy=0; next op completes normally.
- Four back-to-back ops (00, 01, 10, 11) with res_ready=1 -> four results in order; the pop (rd3) is issued exactly four times.

Source files
------------

// File: rtl/xor_bus_pkg.sv
// Shared constants and state encoding for the XOR core bus master.
// Register map, default widths and the command FSM states.
package xor_bus_pkg;

  localparam int unsigned DEF_ADDR_W  = 32'd3;
  localparam int unsigned DEF_CNT_W   = 32'd8;
  localparam int unsigned DEF_TIMEOUT = 32'd64;

  localparam int unsigned ADDR_A_STAT = 32'd0;
  localparam int unsigned ADDR_B_STAT = 32'd1;
  localparam int unsigned ADDR_Y_STAT = 32'd2;
  localparam int unsigned ADDR_Y_DATA = 32'd3;
  localparam int unsigned ADDR_A_WR   = 32'd4;
  localparam int unsigned ADDR_B_WR   = 32'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHK_A  = 3'd1,
    WR_A   = 3'd2,
    CHK_B  = 3'd3,
    WR_B   = 3'd4,
    POLL_Y = 3'd5,
    RD_Y   = 3'd6,
    RESP   = 3'd7
  } state_t;

  // States that wait on a bus response and are therefore subject to the timeout.
  function automatic logic is_wait_state(input state_t s);
    logic w;
    case (s)
      CHK_A, WR_A, CHK_B, WR_B, POLL_Y, RD_Y: w = 1'b1;
      default:                                w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/xor_wait_timer.sv
// Stall counter for bus wait states: clears on request, counts when enabled,
// and flags the last allowed cycle before the operation must abort.
module xor_wait_timer #(
  parameter int unsigned CNT_W   = 32'd8,
  parameter int unsigned TIMEOUT = 32'd64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: clear has priority, counting stops at the expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == CNT_W'(TIMEOUT - 32'd1));

endmodule

// File: rtl/xor_bus_master.sv
// Command stage for the XOR register-mapped core: pushes A and B, polls Y,
// pops Y and returns the result (or a timeout error) downstream.
module xor_bus_master
  import xor_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_a,
  input  logic              op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_y,
  output logic              res_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  input  logic              wr_rdy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  input  logic              rd_rdy,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t state_r;
  state_t state_s;
  state_t target_s;

  logic a_r;
  logic b_r;
  logic cond_s;
  logic tmo_s;
  logic inc_s;
  logic clr_s;
  logic expired_s;
  logic rd_done_s;
  logic wr_done_s;
  logic accept_s;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              wr_data_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;

  assign rd_done_s = rd_en && rd_rdy;
  assign wr_done_s = wr_en && wr_rdy;
  assign accept_s  = (state_r == IDLE) && op_valid && op_ready;
  assign clr_s     = (state_s != state_r);

  xor_wait_timer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (clr_s),
    .en     (inc_s),
    .expired(expired_s)
  );

  // Next-state logic; an advancing condition beats expiry in the same cycle.
  always_comb begin
    state_s  = state_r;
    target_s = state_r;
    cond_s   = 1'b0;
    tmo_s    = 1'b0;
    inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CHK_A;
        else          state_s = IDLE;
      end
      CHK_A:  begin cond_s = rd_done_s && rd_data; target_s = WR_A;   end
      WR_A:   begin cond_s = wr_done_s;            target_s = CHK_B;  end
      CHK_B:  begin cond_s = rd_done_s && rd_data; target_s = WR_B;   end
      WR_B:   begin cond_s = wr_done_s;            target_s = POLL_Y; end
      POLL_Y: begin cond_s = rd_done_s && rd_data; target_s = RD_Y;   end
      RD_Y:   begin cond_s = rd_done_s;            target_s = RESP;   end
      RESP: begin
        if (res_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
    if (is_wait_state(state_r)) begin
      if (cond_s) begin
        state_s = target_s;
      end else if (expired_s) begin
        state_s = RESP;
        tmo_s   = 1'b1;
      end else begin
        inc_s = 1'b1;
      end
    end else begin
      inc_s = 1'b0;
    end
  end

  // Bus decode of the upcoming state so the registered outputs track the state exactly.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_W{1'b0}};
    wr_data_s = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = {ADDR_W{1'b0}};
    case (state_s)
      CHK_A:  begin rd_en_s = 1'b1; rd_addr_s = ADDR_W'(ADDR_A_STAT); end
      WR_A:   begin wr_en_s = 1'b1; wr_addr_s = ADDR_W'(ADDR_A_WR); wr_data_s = a_r; end
      CHK_B:  begin rd_en_s = 1'b1; rd_addr_s = ADDR_W'(ADDR_B_STAT); end
      WR_B:   begin wr_en_s = 1'b1; wr_addr_s = ADDR_W'(ADDR_B_WR); wr_data_s = b_r; end
      POLL_Y: begin rd_en_s = 1'b1; rd_addr_s = ADDR_W'(ADDR_Y_STAT); end
      RD_Y:   begin rd_en_s = 1'b1; rd_addr_s = ADDR_W'(ADDR_Y_DATA); end
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // State register and registered stream/bus outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      op_ready  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
      wr_data   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      op_ready  <= (state_s == IDLE);
      busy      <= (state_s != IDLE);
      res_valid <= (state_s == RESP);
      wr_en     <= wr_en_s;
      wr_addr   <= wr_addr_s;
      wr_data   <= wr_data_s;
      rd_en     <= rd_en_s;
      rd_addr   <= rd_addr_s;
    end
  end

  // Operand capture on handshake; later input changes are ignored until IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_r <= 1'b0;
      b_r <= 1'b0;
    end else if (accept_s) begin
      a_r <= op_a;
      b_r <= op_b;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  // Result capture: popped Y on success, forced zero with error flag on timeout.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_y   <= 1'b0;
      res_err <= 1'b0;
    end else if (tmo_s) begin
      res_y   <= 1'b0;
      res_err <= 1'b1;
    end else if ((state_r == RD_Y) && rd_done_s) begin
      res_y   <= rd_data;
      res_err <= 1'b0;
    end else begin
      res_y   <= res_y;
      res_err <= res_err;
    end
  end

  // Saturating count of aborted operations.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (tmo_s && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt <= err_cnt;
    end
  end

endmodule

// File: tb/tb_xor_bus_master.sv
// Directed bench for xor_bus_master: a default instance plus a TIMEOUT=4 instance
// sharing stimulus, with a small bench-side model of the core's register map.
module tb_xor_bus_master;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic op_valid, op_a, op_b, res_ready, wr_rdy, rd_rdy, rd_data;
  logic op_ready, res_valid, res_y, res_err, wr_en, wr_data, rd_en, busy;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] err_cnt;
  logic t4_op_ready, t4_res_valid, t4_res_y, t4_res_err, t4_wr_en, t4_wr_data, t4_rd_en, t4_busy;
  logic [2:0] t4_wr_addr, t4_rd_addr;
  logic [7:0] t4_err_cnt;

  logic a_stat_ok;
  logic y_val;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   pops = 0;
  logic res_log[$];
  logic [8:0] tbl [1:6];

  xor_bus_master dut (
    .CLK(CLK), .RST_N(RST_N), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_err(res_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .busy(busy), .err_cnt(err_cnt)
  );

  xor_bus_master #(.TIMEOUT(4)) dut_t4 (
    .CLK(CLK), .RST_N(RST_N), .op_valid(op_valid), .op_ready(t4_op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(t4_res_valid), .res_ready(res_ready), .res_y(t4_res_y), .res_err(t4_res_err),
    .wr_en(t4_wr_en), .wr_addr(t4_wr_addr), .wr_data(t4_wr_data), .wr_rdy(wr_rdy),
    .rd_en(t4_rd_en), .rd_addr(t4_rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .busy(t4_busy), .err_cnt(t4_err_cnt)
  );

  // Core model: status registers and Y data, addressed by the main instance.
  always_comb begin
    case (rd_addr)
      3'd0:    rd_data = a_stat_ok;
      3'd1:    rd_data = 1'b1;
      3'd2:    rd_data = 1'b1;
      3'd3:    rd_data = y_val;
      default: rd_data = 1'b0;
    endcase
  end

  always @(posedge CLK) begin
    if (rd_en && rd_rdy && (rd_addr == 3'd3)) pops <= pops + 1;
    if (res_valid && res_ready) res_log.push_back(res_y);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] bus_vec();
    return {rd_en, rd_addr, wr_en, wr_addr, wr_data};
  endfunction

  // Waits (bounded) for op_ready, then presents the pair for exactly one handshake.
  task automatic send_op(input logic a, input logic b);
    int n = 0;
    @(negedge CLK);
    while (!op_ready && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check_eq("op_ready_wait", {31'd0, op_ready}, 32'd1);
    op_a = a; op_b = b; y_val = a ^ b; op_valid = 1'b1;
    @(posedge CLK);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check_eq({tag, "_wait"}, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic finish_resp();
    @(negedge CLK);
    res_ready = 1'b1;
    @(posedge CLK);
    #1 res_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pops0;
    int n0;
    tbl[1] = {1'b1, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[2] = {1'b0, 3'd0, 1'b1, 3'd4, 1'b1};
    tbl[3] = {1'b1, 3'd1, 1'b0, 3'd0, 1'b0};
    tbl[4] = {1'b0, 3'd0, 1'b1, 3'd5, 1'b0};
    tbl[5] = {1'b1, 3'd2, 1'b0, 3'd0, 1'b0};
    tbl[6] = {1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
    op_valid = 1'b0; op_a = 1'b0; op_b = 1'b0; res_ready = 1'b0;
    wr_rdy = 1'b1; rd_rdy = 1'b1; a_stat_ok = 1'b1; y_val = 1'b0;

    // Reset state
    #23;
    check_eq("rst_bus", {23'd0, bus_vec()}, 32'd0);
    check_eq("rst_res", {29'd0, res_valid, res_y, res_err}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_ready", {30'd0, op_ready, busy}, 32'd2);
    check_eq("rst_errcnt", {24'd0, err_cnt}, 32'd0);

    // Basic op a=1 b=0: exact bus sequence and latency
    send_op(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      check_eq($sformatf("seq_c%0d", i), {23'd0, bus_vec()}, {23'd0, tbl[i]});
      check_eq($sformatf("seq_valid_c%0d", i), {31'd0, res_valid}, 32'd0);
    end
    @(negedge CLK);
    check_eq("basic_c7", {28'd0, res_valid, res_y, res_err, op_ready}, 32'b1100);
    check_eq("basic_c7_bus", {30'd0, rd_en, wr_en}, 32'd0);
    finish_resp();

    // Status A not-full for 5 cycles before it frees up
    a_stat_ok = 1'b0;
    send_op(1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      check_eq($sformatf("stall_a_c%0d", i), {23'd0, bus_vec()}, {23'd0, tbl[1]});
    end
    a_stat_ok = 1'b1;
    @(negedge CLK);
    check_eq("stall_a_wr", {23'd0, bus_vec()}, {23'd0, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0});
    wait_res("stall_a");
    check_eq("stall_a_res", {30'd0, res_y, res_err}, 32'b10);
    check_eq("stall_a_errcnt", {24'd0, err_cnt}, 32'd0);
    finish_resp();

    // Timeout on the TIMEOUT=4 instance, preceded by a good op leaving res_y=1
    pulse_reset();
    send_op(1'b1, 1'b0);
    wait_res("pre_tmo");
    check_eq("pre_tmo_t4y", {31'd0, t4_res_y}, 32'd1);
    finish_resp();
    wr_rdy = 1'b0;
    send_op(1'b1, 1'b1);
    @(negedge CLK);
    check_eq("tmo_c1", {30'd0, t4_rd_en, t4_wr_en}, 32'b10);
    for (int i = 2; i <= 5; i++) begin
      @(negedge CLK);
      check_eq($sformatf("tmo_stall_c%0d", i), {30'd0, t4_wr_en, t4_res_valid}, 32'b10);
    end
    @(negedge CLK);
    check_eq("tmo_res", {28'd0, t4_res_valid, t4_res_err, t4_res_y, t4_wr_en}, 32'b1100);
    check_eq("tmo_errcnt", {24'd0, t4_err_cnt}, 32'd1);
    check_eq("tmo_main_busy", {31'd0, res_valid}, 32'd0);
    wr_rdy = 1'b1;
    res_ready = 1'b1;
    repeat (12) @(posedge CLK);
    #1 res_ready = 1'b0;
    send_op(1'b1, 1'b0);
    n = 0;
    while (!t4_res_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check_eq("post_tmo_wait", {31'd0, t4_res_valid}, 32'd1);
    check_eq("post_tmo_res", {30'd0, t4_res_y, t4_res_err}, 32'b10);
    check_eq("post_tmo_errcnt", {24'd0, t4_err_cnt}, 32'd1);
    finish_resp();

    // Back-pressure in RESP
    send_op(1'b0, 1'b1);
    wait_res("hold");
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      check_eq($sformatf("hold_c%0d", i), {29'd0, res_valid, res_y, op_ready}, 32'b110);
    end
    res_ready = 1'b1;
    @(posedge CLK);
    #1 res_ready = 1'b0;
    @(negedge CLK);
    check_eq("hold_release", {29'd0, op_ready, busy, res_valid}, 32'b100);

    // Asynchronous reset in the middle of WR_B
    send_op(1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    check_eq("rst_wrb_pre", {23'd0, bus_vec()}, {23'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1});
    #1 RST_N = 1'b0;
    #1;
    check_eq("rst_wrb_bus", {23'd0, bus_vec()}, 32'd0);
    check_eq("rst_wrb_state", {29'd0, busy, res_valid, res_err}, 32'd0);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_wrb_idle", {30'd0, op_ready, busy}, 32'b10);
    send_op(1'b1, 1'b0);
    wait_res("rst_wrb_next");
    check_eq("rst_wrb_next_res", {30'd0, res_y, res_err}, 32'b10);
    finish_resp();

    // Four back-to-back ops with res_ready held high
    @(negedge CLK);
    pops0 = pops;
    n0 = res_log.size();
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kv;
      kv = 2'(k);
      send_op(kv[1], kv[0]);
    end
    n = 0;
    @(negedge CLK);
    while ((busy || !op_ready) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    res_ready = 1'b0;
    check_eq("b2b_idle", {31'd0, busy}, 32'd0);
    check_eq("b2b_pops", pops - pops0, 32'd4);
    check_eq("b2b_count", res_log.size() - n0, 32'd4);
    if (res_log.size() - n0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        logic [1:0] kv;
        kv = 2'(k);
        check_eq($sformatf("b2b_res%0d", k), {31'd0, res_log[n0 + k]}, {31'd0, kv[1] ^ kv[0]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
